// File: rtl/hv_bundler.sv
`default_nettype none
// ============================================================================
// Module   : hv_bundler
// Brief    : Bit-wise signed up/down bundling of stored hypervectors with a
//            sign threshold and one-cycle write-back of the majority vector.
// Revision : 1.0 - initial release
// ============================================================================
module hv_bundler #(
    parameter int DIM   = 1023,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           store,
    input  logic [DIM:0]   core_result,
    input  logic           last,
    input  logic [DIM:0]   tie_bits,
    output logic           wb_en,
    output logic [DIM:0]   wb_data,
    output logic [15:0]    vec_cnt,
    output logic           done,
    output logic           drop
);

    // Symmetric saturation limits: +(2^(CNT_W-1)-1) and its negation.
    localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] c_cnt_min = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};
    localparam logic [15:0]      c_vec_max = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_SIGN = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_vec_cnt;
    logic [DIM:0]  r_wb_data;
    logic          r_drop;
    logic [DIM:0]  w_pos;
    logic [DIM:0]  w_zero;
    logic [DIM:0]  w_major;
    logic          w_empty;
    logic          w_acc_store;
    logic          w_clear;

    assign w_empty     = (r_vec_cnt == 16'd0);
    assign w_acc_store = (r_state == ST_ACC) && store;
    assign w_clear     = !run || (r_state == ST_WB);

    generate
        for (genvar i = 0; i <= DIM; i++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_clear) begin
                    r_cnt <= '0;
                end else if (w_acc_store) begin
                    if (core_result[i]) begin
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end else if (r_cnt != c_cnt_min) begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
            end

            assign w_zero[i] = (r_cnt == '0);
            assign w_pos[i]  = !r_cnt[CNT_W-1] && !w_zero[i];
        end
    endgenerate

    assign w_major = w_pos | (w_zero & tie_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt <= 16'd0;
        end else if (w_clear) begin
            r_vec_cnt <= 16'd0;
        end else if (w_acc_store && (r_vec_cnt != c_vec_max)) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end

    // An empty bundle still ends with a defined all-zero vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data <= '0;
        end else if (!run) begin
            r_wb_data <= '0;
        end else if (r_state == ST_SIGN) begin
            r_wb_data <= w_empty ? '0 : w_major;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (!run) begin
            r_drop <= 1'b0;
        end else if ((store || last) && (r_state != ST_ACC)) begin
            r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        wb_en        = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (last) begin
                    w_state_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                if (w_empty) begin
                    done         = 1'b1;
                    w_state_next = ST_ACC;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_WB: begin
                wb_en        = 1'b1;
                done         = 1'b1;
                w_state_next = ST_ACC;
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
        // Clearing run aborts any bundle in flight without a write-back.
        if (!run) begin
            w_state_next = ST_ACC;
            wb_en        = 1'b0;
            done         = 1'b0;
        end
    end

    assign wb_data = r_wb_data;
    assign vec_cnt = r_vec_cnt;
    assign drop    = r_drop;

endmodule
`default_nettype wire
